// File: rtl/image_line_fifo_pkg.sv
// Shared constants for the image line FIFO.
// Defaults size one 640-pixel byte line in a 1024-entry buffer.
package image_line_fifo_pkg;

  localparam int DATA_W_DEF = 8;
  localparam int ADDR_W_DEF = 10;
  localparam int DEPTH      = 2 ** ADDR_W_DEF;
  localparam int LINE_LEN   = 640;

endpackage

// File: rtl/image_fifo_ram.sv
// Simple dual-port RAM: synchronous write, registered read.
// The read register resets to 0; the array itself is never cleared.
module image_fifo_ram
  import image_line_fifo_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int ADDR_W = ADDR_W_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [ADDR_W-1:0] waddr,
  input  logic [DATA_W-1:0] wdata,
  input  logic              re,
  input  logic [ADDR_W-1:0] raddr,
  output logic [DATA_W-1:0] rdata
);

  logic [DATA_W-1:0] mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (we) begin
      mem[waddr] <= wdata;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rdata <= '0;
    end else if (re) begin
      rdata <= mem[raddr];
    end
  end

endmodule

// File: rtl/image_line_fifo.sv
// Single-clock byte FIFO buffering one image line.
// Standard read: dout/valid follow an accepted read by one cycle.
module image_line_fifo
  import image_line_fifo_pkg::*;
#(
  parameter int DATA_W           = DATA_W_DEF,
  parameter int ADDR_W           = ADDR_W_DEF,
  parameter int PROG_FULL_THRESH = LINE_LEN
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [DATA_W-1:0] din,
  input  logic              wr_en,
  input  logic              rd_en,
  output logic [DATA_W-1:0] dout,
  output logic              full,
  output logic              empty,
  output logic              valid,
  output logic              prog_full
);

  localparam int CW = ADDR_W + 1;
  localparam logic [CW-1:0] CNT_FULL = {1'b1, {ADDR_W{1'b0}}};
  localparam logic [CW-1:0] CNT_PF   = CW'(PROG_FULL_THRESH);

  logic [ADDR_W-1:0] wr_ptr;
  logic [ADDR_W-1:0] rd_ptr;
  logic [CW-1:0]     count;
  logic [CW-1:0]     count_nxt;
  logic              wr_acc;
  logic              rd_acc;

  // Flags come from the registered count only, so full blocks a
  // write even when a read is accepted on the same edge.
  assign empty     = (count == '0);
  assign full      = (count == CNT_FULL);
  assign prog_full = (count >= CNT_PF);

  assign wr_acc = wr_en && !full;
  assign rd_acc = rd_en && !empty;

  always_comb begin
    count_nxt = count;
    case ({wr_acc, rd_acc})
      2'b10:   count_nxt = count + CW'(1);
      2'b01:   count_nxt = count - CW'(1);
      default: count_nxt = count;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      valid  <= 1'b0;
    end else begin
      if (wr_acc) begin
        wr_ptr <= wr_ptr + ADDR_W'(1);
      end
      if (rd_acc) begin
        rd_ptr <= rd_ptr + ADDR_W'(1);
      end
      count <= count_nxt;
      valid <= rd_acc;
    end
  end

  image_fifo_ram #(
    .DATA_W (DATA_W),
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk   (clk),
    .rst_n (rst_n),
    .we    (wr_acc),
    .waddr (wr_ptr),
    .wdata (din),
    .re    (rd_acc),
    .raddr (rd_ptr),
    .rdata (dout)
  );

endmodule

// File: tb/tb_image_line_fifo.sv
// Self-checking bench for image_line_fifo.
// Hand-computed vector table plus model-checked line sequences.
module tb_image_line_fifo;

  logic       clk;
  logic       rst_n;
  logic [7:0] din;
  logic       wr_en;
  logic       rd_en;
  logic [7:0] dout;
  logic       full;
  logic       empty;
  logic       valid;
  logic       prog_full;

  int checks;
  int errors;

  logic [7:0] q[$];
  int         mcnt;
  logic [7:0] mdout;
  logic       mvalid;

  image_line_fifo dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .din       (din),
    .wr_en     (wr_en),
    .rd_en     (rd_en),
    .dout      (dout),
    .full      (full),
    .empty     (empty),
    .valid     (valid),
    .prog_full (prog_full)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic       w;
    logic       r;
    logic [7:0] d;
    logic [7:0] e_dout;
    logic       e_valid;
    logic       e_empty;
    logic       e_full;
    logic       e_pf;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp,
               $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_reset();
    q.delete();
    mcnt   = 0;
    mdout  = 8'h00;
    mvalid = 1'b0;
  endtask

  // One cycle against the behavioural model, checking all outputs.
  task automatic cyc(input logic w, input logic r, input logic [7:0] d,
                     input string tag);
    logic wa;
    logic ra;
    wa = w && (mcnt < 1024);
    ra = r && (mcnt > 0);
    wr_en = w;
    rd_en = r;
    din   = d;
    tick();
    mvalid = ra;
    if (ra) begin
      mdout = q.pop_front();
      mcnt--;
    end
    if (wa) begin
      q.push_back(d);
      mcnt++;
    end
    chk({tag, ".valid"}, valid, mvalid);
    if (mvalid) chk({tag, ".dout"}, dout, mdout);
    chk({tag, ".empty"}, empty, mcnt == 0);
    chk({tag, ".full"}, full, mcnt == 1024);
    chk({tag, ".prog_full"}, prog_full, mcnt >= 640);
  endtask

  task automatic do_reset(input int cycles);
    wr_en = 1'b0;
    rd_en = 1'b0;
    din   = 8'h00;
    rst_n = 1'b0;
    for (int i = 0; i < cycles; i++) tick();
    rst_n = 1'b1;
    model_reset();
    tick();
  endtask

  vec_t vt[9];

  initial begin
    checks = 0;
    errors = 0;
    model_reset();

    do_reset(50);
    chk("rst.empty", empty, 1'b1);
    chk("rst.full", full, 1'b0);
    chk("rst.prog_full", prog_full, 1'b0);
    chk("rst.valid", valid, 1'b0);
    chk("rst.dout", dout, 8'h00);

    vt[0] = '{1, 0, 8'h11, 8'h00, 0, 0, 0, 0};
    vt[1] = '{1, 0, 8'h22, 8'h00, 0, 0, 0, 0};
    vt[2] = '{0, 1, 8'h00, 8'h11, 1, 0, 0, 0};
    vt[3] = '{1, 1, 8'h33, 8'h22, 1, 0, 0, 0};
    vt[4] = '{0, 0, 8'h00, 8'h22, 0, 0, 0, 0};
    vt[5] = '{0, 1, 8'h00, 8'h33, 1, 1, 0, 0};
    vt[6] = '{0, 1, 8'h00, 8'h33, 0, 1, 0, 0};
    vt[7] = '{1, 1, 8'h44, 8'h33, 0, 0, 0, 0};
    vt[8] = '{0, 1, 8'h00, 8'h44, 1, 1, 0, 0};
    for (int i = 0; i < 9; i++) begin
      wr_en = vt[i].w;
      rd_en = vt[i].r;
      din   = vt[i].d;
      tick();
      chk($sformatf("vec%0d.dout", i), dout, vt[i].e_dout);
      chk($sformatf("vec%0d.valid", i), valid, vt[i].e_valid);
      chk($sformatf("vec%0d.empty", i), empty, vt[i].e_empty);
      chk($sformatf("vec%0d.full", i), full, vt[i].e_full);
      chk($sformatf("vec%0d.pf", i), prog_full, vt[i].e_pf);
    end

    // Asynchronous reset between edges with data buffered.
    wr_en = 1'b1;
    rd_en = 1'b0;
    din   = 8'h5a;
    tick();
    tick();
    wr_en = 1'b0;
    rd_en = 1'b1;
    tick();
    rd_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    chk("arst.empty", empty, 1'b1);
    chk("arst.valid", valid, 1'b0);
    chk("arst.dout", dout, 8'h00);
    chk("arst.full", full, 1'b0);
    tick();
    rst_n = 1'b1;
    model_reset();
    tick();
    chk("arst.post_empty", empty, 1'b1);

    for (int l = 0; l < 2; l++) begin
      for (int i = 0; i < 640; i++)
        cyc(1, 0, 8'($urandom_range(0, 255)), $sformatf("lw%0d", l));
      for (int i = 0; i < 640; i++)
        cyc(0, 1, 8'h00, $sformatf("lr%0d", l));
      cyc(0, 0, 8'h00, $sformatf("lidle%0d", l));
      chk($sformatf("lend%0d.empty", l), empty, 1'b1);
    end

    for (int i = 0; i < 1025; i++)
      cyc(1, 0, 8'($urandom_range(0, 255)), "ovf_w");
    chk("ovf.full", full, 1'b1);
    for (int i = 0; i < 1024; i++)
      cyc(0, 1, 8'h00, "ovf_r");
    chk("ovf.empty", empty, 1'b1);

    cyc(0, 1, 8'h00, "udf");
    chk("udf.dout_hold", dout, mdout);
    chk("udf.valid", valid, 1'b0);

    for (int i = 0; i < 5; i++)
      cyc(1, 0, 8'($urandom_range(0, 255)), "sim_fill");
    for (int i = 0; i < 100; i++)
      cyc(1, 1, 8'($urandom_range(0, 255)), "sim");
    chk("sim.count", mcnt, 5);
    for (int i = 0; i < 5; i++)
      cyc(0, 1, 8'h00, "sim_drain");
    chk("sim.empty", empty, 1'b1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
